logic_op_arbiter: RTL and testbench
===================================

Name: logic_op_arbiter

Overview:
- Shares one registered WIDTH-bit two-operand logic unit between NREQ requesters.
- The unit performs NOT, AND, OR, NAND, NOR, XOR and XNOR.
- A round-robin arbiter selects one requester, latches its opcode and operands, executes the operation, then returns the tagged result.
- Sits between requesting client blocks and the gate-level logic datapath, and sequences that datapath one operation at a time.

Parameters:
- WIDTH, 8, operand and result width in bits.
- NREQ, 4, number of requesters (2..8).
- IDW, 2, requester-id width; must equal $clog2(NREQ).

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous active-high reset.
- req  in  NREQ  per-requester request level.
- op  in  3*NREQ  flattened opcodes; requester i uses op[3i+2:3i].
- a_in  in  WIDTH*NREQ  flattened operand A; requester i uses a_in[WIDTH*i +: WIDTH].
- b_in  in  WIDTH*NREQ  flattened operand B; same packing as a_in.
- gnt  out  NREQ  one-hot grant, high for exactly one cycle per accepted request.
- busy  out  1  high whenever the FSM is not IDLE.
- res  out  WIDTH  operation result.
- res_valid  out  1  one-cycle result strobe.
- res_id  out  IDW  index of the requester that owns res.
- err  out  1  illegal-opcode flag, qualified by res_valid.

Behaviour:
- Reset state (asynchronous, active-high): state=IDLE, gnt=0, busy=0, res=0, res_valid=0, res_id=0, err=0, RR pointer=NREQ-1 (requester 0 wins first). Operand/opcode latches=0.
- Reset mid-operation aborts the operation silently. No res_valid is produced for it.
- FSM has three states: IDLE, EXEC, RESP.
- IDLE, with any req bit high at rising edge E0:
  - Choose the winner as the first set req index searching upward from pointer+1, wrapping modulo NREQ.
  - Latch that requester's op, a and b.
  - Go to EXEC.
  - gnt[winner]=1 during EXEC only.
- IDLE, with no req high: stay in IDLE; outputs hold except res_valid=0.
- EXEC, at edge E1:
  - Load res from the latched operands, res_id=winner.
  - Set err=1 if opcode==7.
  - Go to RESP.
- RESP: res_valid=1 for this single cycle. At edge E2: pointer=winner, go to IDLE.
- Latency: request sampled at E0 -> gnt visible E0..E1 -> res_valid visible E1..E2.
  - Maximum throughput is one operation per 3 cycles.
  - A req held continuously is re-arbitrated at E2 and counts as a new request.
- Opcode map (bitwise, all WIDTH bits):
  - 0: res=~a (b ignored)
  - 1: a&b
  - 2: a|b
  - 3: ~(a&b)
  - 4: ~(a|b)
  - 5: a^b
  - 6: ~(a^b)
  - 7: illegal, res=0 and err=1
- err is 0 for all legal opcodes.
- res, res_id and err hold their values after RESP until the next EXEC load. Consumers use them only when res_valid=1.
- Requester protocol:
  - Hold req, op and operands stable until gnt is seen.
  - Operand inputs are don't-care after gnt because they are latched at E0.
  - Dropping req before grant withdraws the request with no side effects.
- Fairness: after requester k is served, k has lowest priority. Any continuously requesting client is served within NREQ arbitrations.
- Simultaneous events:
  - req changes during EXEC/RESP are ignored until IDLE.
  - A winner's req falling during EXEC does not cancel its operation.
- busy=1 in EXEC and RESP, 0 in IDLE.
- Exactly one gnt bit is high at a time, never more. gnt and res_valid are never high in the same cycle.

Test Plan:
- Reset then req=0001, op0=1, a0=8'hF0, b0=8'h3C -> gnt=0001 one cycle after the sampling edge; next cycle res_valid=1, res=8'h30, res_id=0, err=0.
- req=1111 held continuously, all op=5 -> grant order 0,1,2,3,0.
  - Each res_valid is 3 cycles apart.
  - res_id sequence matches the grant order.
- Sweep op 0..6 on one requester with a=8'hA5, b=8'h0F -> res = 5A, 05, AF, FA, 50, AA, 55 respectively, err=0 each time.
- op=7, a=8'hFF, b=8'hFF -> res_valid=1, res=8'h00, err=1; the next legal op clears err.
- rst asserted during EXEC (requester 2 granted), released after 2 cycles -> all outputs 0 immediately and no res_valid. The next request with req=0110 is granted to requester 1 (pointer reset).
- req[3] pulses for one cycle while the FSM serves requester 0 -> requester 3 is never granted; only one res_valid is observed.

Source files
------------

// File: rtl/logic_op_arbiter_if.sv
// Request/response bundle between client blocks and the shared logic unit.
interface logic_op_arbiter_if #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4,
  parameter int IDW   = 2
) ();
  logic [NREQ-1:0]       req;
  logic [3*NREQ-1:0]     op;
  logic [WIDTH*NREQ-1:0] a_in;
  logic [WIDTH*NREQ-1:0] b_in;
  logic [NREQ-1:0]       gnt;
  logic                  busy;
  logic [WIDTH-1:0]      res;
  logic                  res_valid;
  logic [IDW-1:0]        res_id;
  logic                  err;

  modport master (
    output req, op, a_in, b_in,
    input  gnt, busy, res, res_valid, res_id, err
  );

  modport slave (
    input  req, op, a_in, b_in,
    output gnt, busy, res, res_valid, res_id, err
  );
endinterface

// File: rtl/logic_op_arbiter.sv
// Round-robin sharing of one registered bitwise logic unit among NREQ clients.
// One operation in flight: IDLE (arbitrate+latch) -> EXEC (compute) -> RESP (strobe).
module logic_op_arbiter #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4,
  parameter int IDW   = 2
) (
  input  logic               clk,
  input  logic               rst,
  logic_op_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t                     state;
  logic [IDW-1:0]             ptr;
  logic [IDW-1:0]             win;
  logic                       win_found;
  logic [IDW-1:0]             win_q;
  logic [2:0]                 op_q;
  logic [WIDTH-1:0]           a_q;
  logic [WIDTH-1:0]           b_q;
  logic [NREQ-1:0]            gnt_q;
  logic [WIDTH-1:0]           res_q;
  logic                       res_valid_q;
  logic [IDW-1:0]             res_id_q;
  logic                       err_q;

  logic [NREQ-1:0][2:0]       op_l;
  logic [NREQ-1:0][WIDTH-1:0] a_l;
  logic [NREQ-1:0][WIDTH-1:0] b_l;

  // Per-lane views of the flattened request buses.
  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_lane
      assign op_l[gi] = bus.op[3*gi +: 3];
      assign a_l[gi]  = bus.a_in[WIDTH*gi +: WIDTH];
      assign b_l[gi]  = bus.b_in[WIDTH*gi +: WIDTH];
    end
  endgenerate

  function automatic logic [WIDTH-1:0] alu(input logic [2:0] o,
                                           input logic [WIDTH-1:0] a,
                                           input logic [WIDTH-1:0] b);
    case (o)
      3'd0:    alu = ~a;
      3'd1:    alu = a & b;
      3'd2:    alu = a | b;
      3'd3:    alu = ~(a & b);
      3'd4:    alu = ~(a | b);
      3'd5:    alu = a ^ b;
      3'd6:    alu = ~(a ^ b);
      default: alu = '0;
    endcase
  endfunction

  // Round-robin pick: first set req searching up from ptr+1, wrapping; the
  // last-served requester is visited last so it has lowest priority.
  always_comb begin
    win       = '0;
    win_found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!win_found && bus.req[(int'(ptr) + k) % NREQ]) begin
        win       = IDW'((int'(ptr) + k) % NREQ);
        win_found = 1'b1;
      end
    end
  end

  // Control FSM with all outputs registered; reset aborts any operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      ptr         <= IDW'(NREQ - 1);
      win_q       <= '0;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      gnt_q       <= '0;
      res_q       <= '0;
      res_valid_q <= 1'b0;
      res_id_q    <= '0;
      err_q       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          res_valid_q <= 1'b0;
          if (win_found) begin
            win_q <= win;
            op_q  <= op_l[win];
            a_q   <= a_l[win];
            b_q   <= b_l[win];
            gnt_q <= {{(NREQ-1){1'b0}}, 1'b1} << win;
            state <= EXEC;
          end
        end
        EXEC: begin
          gnt_q       <= '0;
          res_q       <= alu(op_q, a_q, b_q);
          res_id_q    <= win_q;
          err_q       <= (op_q == 3'd7);
          res_valid_q <= 1'b1;
          state       <= RESP;
        end
        RESP: begin
          res_valid_q <= 1'b0;
          ptr         <= win_q;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.busy      = (state != IDLE);
  assign bus.res       = res_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_id    = res_id_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_logic_op_arbiter.sv
// Bench for logic_op_arbiter: vector table, corner sequences, random traffic.
module tb_logic_op_arbiter;
  localparam int WIDTH = 8;
  localparam int NREQ  = 4;
  localparam int IDW   = 2;

  logic clk = 1'b0;
  logic rst;
  int   errs   = 0;
  int   checks = 0;
  int   cyc    = 0;
  int   last   = NREQ - 1;   // model: last-served requester
  int   t_valid;

  logic_op_arbiter_if #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW)) bus ();

  logic_op_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic       err;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Behavioural model of the opcode table.
  function automatic logic [7:0] model_res(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b);
    case (o)
      3'd0: return ~a;
      3'd1: return a & b;
      3'd2: return a | b;
      3'd3: return ~(a & b);
      3'd4: return ~(a | b);
      3'd5: return a ^ b;
      3'd6: return ~(a ^ b);
      default: return 8'h00;
    endcase
  endfunction

  // Rotating-priority model: scan from the one after the last served client.
  function automatic int model_pick(input logic [NREQ-1:0] r, input int lst);
    for (int k = 1; k <= NREQ; k++)
      if (r[(lst + k) % NREQ]) return (lst + k) % NREQ;
    return -1;
  endfunction

  task automatic set_lane(input int i, input logic [2:0] o, input logic [7:0] a, input logic [7:0] b);
    bus.op[3*i +: 3]         = o;
    bus.a_in[WIDTH*i +: WIDTH] = a;
    bus.b_in[WIDTH*i +: WIDTH] = b;
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_gnt"}, 32'(bus.gnt), 0);
    chk({tag, "_busy"}, 32'(bus.busy), 0);
    chk({tag, "_vld"}, 32'(bus.res_valid), 0);
    chk({tag, "_res"}, 32'(bus.res), 0);
    chk({tag, "_id"}, 32'(bus.res_id), 0);
    chk({tag, "_err"}, 32'(bus.err), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.req = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    last = NREQ - 1;
  endtask

  // One full arbitration: present r, check grant, result and return to idle.
  task automatic arb(input logic [NREQ-1:0] r, input bit keep, output int w);
    logic [2:0] o;
    logic [7:0] a, b;
    int n;
    n = 0;
    @(negedge clk);
    while (bus.busy && n < 20) begin @(negedge clk); n++; end
    if (bus.busy) begin chk("idle_timeout", 1, 0); w = -1; return; end
    bus.req = r;
    w = model_pick(r, last);
    o = bus.op[3*w +: 3];
    a = bus.a_in[WIDTH*w +: WIDTH];
    b = bus.b_in[WIDTH*w +: WIDTH];
    @(posedge clk); #1;
    chk("gnt", 32'(bus.gnt), 32'(1) << w);
    chk("busy_exec", 32'(bus.busy), 1);
    chk("vld_exec", 32'(bus.res_valid), 0);
    for (int i = 0; i < NREQ; i++) begin
      bus.a_in[WIDTH*i +: WIDTH] = 8'($urandom);
      bus.b_in[WIDTH*i +: WIDTH] = 8'($urandom);
    end
    if (!keep) bus.req = '0;
    @(posedge clk); #1;
    chk("vld_resp", 32'(bus.res_valid), 1);
    chk("gnt_resp", 32'(bus.gnt), 0);
    chk("res", 32'(bus.res), 32'(model_res(o, a, b)));
    chk("res_id", 32'(bus.res_id), 32'(w));
    chk("err", 32'(bus.err), 32'(o == 3'd7));
    t_valid = cyc;
    @(posedge clk); #1;
    chk("vld_idle", 32'(bus.res_valid), 0);
    chk("busy_idle", 32'(bus.busy), 0);
    last = w;
  endtask

  initial begin
    int w, t_prev, cnt3, cntv;
    int order[5];
    order = '{0, 1, 2, 3, 0};

    vecs[0] = '{3'd1, 8'hF0, 8'h3C, 8'h30, 1'b0};
    vecs[1] = '{3'd0, 8'hA5, 8'h0F, 8'h5A, 1'b0};
    vecs[2] = '{3'd1, 8'hA5, 8'h0F, 8'h05, 1'b0};
    vecs[3] = '{3'd2, 8'hA5, 8'h0F, 8'hAF, 1'b0};
    vecs[4] = '{3'd3, 8'hA5, 8'h0F, 8'hFA, 1'b0};
    vecs[5] = '{3'd4, 8'hA5, 8'h0F, 8'h50, 1'b0};
    vecs[6] = '{3'd5, 8'hA5, 8'h0F, 8'hAA, 1'b0};
    vecs[7] = '{3'd6, 8'hA5, 8'h0F, 8'h55, 1'b0};
    vecs[8] = '{3'd7, 8'hFF, 8'hFF, 8'h00, 1'b1};
    vecs[9] = '{3'd1, 8'hFF, 8'h0F, 8'h0F, 1'b0};

    rst = 1'b1;
    bus.req = '0; bus.op = '0; bus.a_in = '0; bus.b_in = '0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b0;

    // Vector table on requester 0.
    for (int i = 0; i < 10; i++) begin
      set_lane(0, vecs[i].op, vecs[i].a, vecs[i].b);
      arb(4'b0001, 1'b0, w);
      chk("tbl_res", 32'(bus.res), 32'(vecs[i].res));
      chk("tbl_err", 32'(bus.err), 32'(vecs[i].err));
    end

    // req[3] pulses only while requester 0 is being served.
    @(negedge clk);
    set_lane(0, 3'd2, 8'h12, 8'h34);
    set_lane(3, 3'd2, 8'h56, 8'h78);
    bus.req = 4'b0001;
    @(posedge clk); #1;
    chk("pulse_gnt", 32'(bus.gnt), 32'h1);
    bus.req = 4'b1000;
    @(posedge clk); #1;
    chk("pulse_vld", 32'(bus.res_valid), 1);
    chk("pulse_id", 32'(bus.res_id), 0);
    bus.req = '0;
    cnt3 = 0; cntv = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (bus.gnt[3]) cnt3++;
      if (bus.res_valid) cntv++;
    end
    chk("pulse_no_gnt3", 32'(cnt3), 0);
    chk("pulse_no_extra_vld", 32'(cntv), 0);
    last = 0;

    // Reset while requester 2 is in EXEC.
    @(negedge clk);
    set_lane(2, 3'd5, 8'hC3, 8'h3C);
    bus.req = 4'b0100;
    @(posedge clk); #1;
    chk("rst_gnt", 32'(bus.gnt), 32'h4);
    rst = 1'b1;
    #1;
    check_idle_outputs("rst_mid");
    bus.req = '0;
    cntv = 0;
    repeat (2) begin @(posedge clk); #1; if (bus.res_valid) cntv++; end
    @(negedge clk);
    rst = 1'b0;
    last = NREQ - 1;
    repeat (2) begin @(posedge clk); #1; if (bus.res_valid) cntv++; end
    chk("rst_no_vld", 32'(cntv), 0);
    set_lane(1, 3'd1, 8'hAA, 8'hF0);
    set_lane(2, 3'd1, 8'h55, 8'hF0);
    arb(4'b0110, 1'b0, w);
    chk("rst_ptr_winner", 32'(w), 1);

    // Continuous 1111 from a fresh reset: order 0,1,2,3,0 every 3 cycles.
    do_reset();
    for (int i = 0; i < NREQ; i++) set_lane(i, 3'd5, 8'(8'h11 * i), 8'h0F);
    t_prev = 0;
    for (int i = 0; i < 5; i++) begin
      arb(4'b1111, 1'b1, w);
      chk("rr_order", 32'(w), 32'(order[i]));
      if (i > 0) chk("rr_spacing", 32'(t_valid - t_prev), 3);
      t_prev = t_valid;
    end
    bus.req = '0;

    // Random traffic against the model.
    for (int it = 0; it < 40; it++) begin
      for (int i = 0; i < NREQ; i++)
        set_lane(i, 3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom));
      arb(4'($urandom_range(1, 15)), 1'($urandom_range(0, 1)), w);
    end
    bus.req = '0;
    repeat (2) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
